// File: rtl/rr_lock_arbiter.sv
// N-way round-robin arbiter with registered one-hot grant and per-owner packet locking.
// Define RR_ARB_LOCK_EN to honour `lock` and build the MAX_HOLD forced-release counter.
module rr_lock_arbiter #(
  parameter int N        = 10,
  parameter int MAX_HOLD = 16,
  parameter int IDXW     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    lock,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam int PW = IDXW + 1;

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] owner;
  logic            found;
  logic [IDXW-1:0] win;
  logic [IDXW-1:0] win_next;
  logic [N-1:0]    win_oh;
  logic [PW-1:0]   pos;
  logic            hold;

  // Search starts at ptr; pos stays below 2N so one conditional subtract wraps it.
  always_comb begin
    found = 1'b0;
    win   = '0;
    pos   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + PW'(i);
      if (pos >= PW'(N)) pos = pos - PW'(N);
      if (!found && req[pos[IDXW-1:0]]) begin
        found = 1'b1;
        win   = pos[IDXW-1:0];
      end
    end
    win_oh      = '0;
    win_oh[win] = 1'b1;
    win_next    = (win == IDXW'(N - 1)) ? '0 : win + 1'b1;
  end

`ifdef RR_ARB_LOCK_EN
  localparam int              HCW      = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0]  HOLD_LIM = HCW'(MAX_HOLD);

  logic [HCW-1:0] hold_cnt;
  logic [N-1:0]   owner_oh;
  logic           others;

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
    others          = |(req & ~owner_oh);
    hold            = (state == GRANT) && req[owner] && lock[owner] &&
                      ((MAX_HOLD == 0) || (hold_cnt < HOLD_LIM) || !others);
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign hold        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      ptr       <= '0;
      owner     <= '0;
`ifdef RR_ARB_LOCK_EN
      hold_cnt  <= '0;
`endif
    end else if (hold) begin
`ifdef RR_ARB_LOCK_EN
      if ((MAX_HOLD != 0) && (hold_cnt != HOLD_LIM)) hold_cnt <= hold_cnt + 1'b1;
`endif
    end else if (found) begin
      state     <= GRANT;
      owner     <= win;
      gnt       <= win_oh;
      gnt_valid <= 1'b1;
      gnt_idx   <= win;
      ptr       <= win_next;
`ifdef RR_ARB_LOCK_EN
      hold_cnt  <= HCW'(1);
`endif
    end else begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Table-driven bench for rr_lock_arbiter: dut_a uses default MAX_HOLD, dut_b uses MAX_HOLD=4.
// Expectations follow the RR_ARB_LOCK_EN setting shared with the RTL build.
module tb_rr_lock_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] req_a = '0, lock_a = '0, req_b = '0, lock_b = '0;
  logic [9:0] gnt_a, gnt_b;
  logic       valid_a, valid_b;
  logic [3:0] idx_a, idx_b;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  rr_lock_arbiter #(.N(10)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .lock(lock_a),
    .gnt(gnt_a), .gnt_valid(valid_a), .gnt_idx(idx_a)
  );

  rr_lock_arbiter #(.N(10), .MAX_HOLD(4)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .lock(lock_b),
    .gnt(gnt_b), .gnt_valid(valid_b), .gnt_idx(idx_b)
  );

  typedef struct {
    bit         rst;
    bit         sel;
    logic [9:0] req;
    logic [9:0] lock;
    logic [9:0] gnt;
    logic       valid;
    logic [3:0] idx;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit r, bit s, logic [9:0] rq, logic [9:0] lk,
                              logic [9:0] g, logic v, logic [3:0] ix);
    vec_t t;
    t.rst = r; t.sel = s; t.req = rq; t.lock = lk;
    t.gnt = g; t.valid = v; t.idx = ix;
    vecs.push_back(t);
  endfunction

  function automatic void add_idx(bit r, bit s, logic [9:0] rq, logic [9:0] lk, int ix);
    add(r, s, rq, lk, 10'(1) << ix, 1'b1, 4'(ix));
  endfunction

  task automatic check(string name, bit s, logic [9:0] g, logic v, logic [3:0] ix);
    logic [9:0] ag;
    logic       av;
    logic [3:0] ai;
    ag = s ? gnt_b : gnt_a;
    av = s ? valid_b : valid_a;
    ai = s ? idx_b : idx_a;
    nvec++;
    if (ag !== g || av !== v || ai !== ix) begin
      nmis++;
      $display("FAIL %s: got gnt=%h valid=%b idx=%0d, expected gnt=%h valid=%b idx=%0d",
               name, ag, av, ai, g, v, ix);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef RR_ARB_LOCK_EN
    int t2[8]  = '{3, 3, 3, 3, 3, 3, 5, 3};
    int t3[10] = '{2, 2, 2, 2, 7, 2, 2, 2, 2, 7};
`else
    int t2[8]  = '{3, 5, 3, 5, 3, 5, 3, 5};
    int t3[10] = '{2, 7, 2, 7, 2, 7, 2, 7, 2, 7};
`endif

    // 1: full-load rotation
    for (int i = 0; i < 11; i++) add_idx(i == 0, 1'b0, 10'h3FF, 10'h000, i % 10);
    // 2: locked packet on requester 3 against requester 5
    for (int i = 0; i < 8; i++) add_idx(i == 0, 1'b0, 10'h028, (i < 6) ? 10'h008 : 10'h000, t2[i]);
    // 3: hold timeout with MAX_HOLD=4
    for (int i = 0; i < 10; i++) add_idx(i == 0, 1'b1, 10'h084, 10'h004, t3[i]);
    // 4: sole locked owner past the hold limit
    for (int i = 0; i < 10; i++) add_idx(i == 0, 1'b1, 10'h004, 10'h004, 2);
    // 5: request drop, pointer follow-through, wrap at N-1, stray lock bits
    add_idx(1'b1, 1'b0, 10'h002, 10'h000, 1);
    add(1'b0, 1'b0, 10'h000, 10'h000, 10'h000, 1'b0, 4'd1);
    add(1'b0, 1'b0, 10'h000, 10'h3FF, 10'h000, 1'b0, 4'd1);
    add_idx(1'b0, 1'b0, 10'h3FF, 10'h000, 2);
    add_idx(1'b0, 1'b0, 10'h001, 10'h000, 0);
    add_idx(1'b0, 1'b0, 10'h200, 10'h000, 9);
    add_idx(1'b0, 1'b0, 10'h201, 10'h000, 0);
    add_idx(1'b0, 1'b0, 10'h3FF, 10'h000, 1);
    add_idx(1'b0, 1'b0, 10'h004, 10'h3FB, 2);
    add_idx(1'b0, 1'b0, 10'h006, 10'h002, 1);

    foreach (vecs[k]) begin
      @(negedge clk);
      if (vecs[k].rst) begin
        rst = 1'b1;
        #1;
        check($sformatf("reset_v%0d", k), vecs[k].sel, 10'h000, 1'b0, 4'd0);
        rst = 1'b0;
      end
      req_a  = vecs[k].sel ? 10'h000 : vecs[k].req;
      lock_a = vecs[k].sel ? 10'h000 : vecs[k].lock;
      req_b  = vecs[k].sel ? vecs[k].req  : 10'h000;
      lock_b = vecs[k].sel ? vecs[k].lock : 10'h000;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", k), vecs[k].sel, vecs[k].gnt, vecs[k].valid, vecs[k].idx);
    end

    // 6: asynchronous reset in the middle of a locked packet
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req_a = 10'h100; lock_a = 10'h100; req_b = '0; lock_b = '0;
    @(posedge clk); #1;
    check("midpkt_grant", 1'b0, 10'h100, 1'b1, 4'd8);
    @(posedge clk); #1;
    check("midpkt_hold", 1'b0, 10'h100, 1'b1, 4'd8);
    #2;
    rst = 1'b1;
    #1;
    check("midpkt_async_reset", 1'b0, 10'h000, 1'b0, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    req_a = 10'h3FF; lock_a = 10'h000;
    @(posedge clk); #1;
    check("post_reset_first", 1'b0, 10'h001, 1'b1, 4'd0);
    @(posedge clk); #1;
    check("post_reset_second", 1'b0, 10'h002, 1'b1, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
